// File: rtl/banner.sv
`timescale 1ns/1ps
// Scrolling four-digit banner. A position pointer selects which slice of the
// message (digit i has value i) is shown; a prescaler paces the scroll steps.
module banner #(
    parameter int unsigned DIV     = 1,   // enabled clocks per scroll step, 1..65536
    parameter int unsigned MSG_LEN = 10   // message length, 4..16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       dir,
    output logic [3:0] dig_3,
    output logic [3:0] dig_2,
    output logic [3:0] dig_1,
    output logic [3:0] dig_0
);

    // Counter wide enough for DIV-1; DIV = 1 still gets a 1-bit (constant zero) counter.
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [3:0]    POS_MAX = 4'(MSG_LEN - 1);
    localparam logic [4:0]    LEN     = 5'(MSG_LEN);

    logic [3:0]    pos_q, pos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step;

    // (p + k) mod MSG_LEN without a divider; p < MSG_LEN and k <= 3 keep one subtract enough.
    function automatic logic [3:0] wrap_add(input logic [3:0] p, input logic [1:0] k);
        logic [4:0] s;
        s = {1'b0, p} + {3'b000, k};
        if (s >= LEN) begin
            s = s - LEN;
        end
        return s[3:0];
    endfunction

    // Next-state: prescaler advances on every enabled edge, position only on a step.
    always_comb begin
        step  = enable && (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        pos_d = pos_q;
        if (enable) begin
            cnt_d = step ? '0 : cnt_q + 1'b1;
        end
        if (step) begin
            if (dir) begin
                pos_d = (pos_q == POS_MAX) ? 4'd0 : pos_q + 4'd1;
            end else begin
                pos_d = (pos_q == 4'd0) ? POS_MAX : pos_q - 4'd1;
            end
        end
    end

    // State registers; reset clears position and prescaler without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= 4'd0;
            cnt_q <= '0;
        end else begin
            pos_q <= pos_d;
            cnt_q <= cnt_d;
        end
    end

    // Displayed digits depend on the registered position only.
    always_comb begin
        dig_3 = pos_q;
        dig_2 = wrap_add(pos_q, 2'd1);
        dig_1 = wrap_add(pos_q, 2'd2);
        dig_0 = wrap_add(pos_q, 2'd3);
    end

endmodule

// File: tb/tb_banner.sv
`timescale 1ns/1ps
// Bench for banner: three instances (DIV=1/MSG_LEN=10, DIV=4/MSG_LEN=10,
// DIV=1/MSG_LEN=16) share one clock. A behavioural model pushes the expected
// display per edge; the observed display is queued after the edge and the
// test tasks pop and compare both.
module tb_banner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [3];
    logic en  [3];
    logic dr  [3];
    logic [15:0] out0, out1, out2;

    banner #(.DIV(1), .MSG_LEN(10)) u_dut (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .dir(dr[0]),
        .dig_3(out0[15:12]), .dig_2(out0[11:8]), .dig_1(out0[7:4]), .dig_0(out0[3:0])
    );
    banner #(.DIV(4), .MSG_LEN(10)) u_div4 (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .dir(dr[1]),
        .dig_3(out1[15:12]), .dig_2(out1[11:8]), .dig_1(out1[7:4]), .dig_0(out1[3:0])
    );
    banner #(.DIV(1), .MSG_LEN(16)) u_m16 (
        .clk(clk), .reset(rst[2]), .enable(en[2]), .dir(dr[2]),
        .dig_3(out2[15:12]), .dig_2(out2[11:8]), .dig_1(out2[7:4]), .dig_0(out2[3:0])
    );

    int divs [3] = '{1, 4, 1};
    int lens [3] = '{10, 10, 16};
    int m_pos [3];
    int m_cnt [3];

    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    int errors = 0;
    int checks = 0;

    function automatic logic [15:0] get_obs(input int i);
        case (i)
            0:       return out0;
            1:       return out1;
            default: return out2;
        endcase
    endfunction

    function automatic logic [15:0] model_out(input int i);
        int p, l;
        p = m_pos[i];
        l = lens[i];
        return {4'(p), 4'((p + 1) % l), 4'((p + 2) % l), 4'((p + 3) % l)};
    endfunction

    // Advance n edges on instance i: model update and expected push before the edge,
    // observed push just after it.
    task automatic tick(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            if (!rst[i] && en[i]) begin
                if (m_cnt[i] == divs[i] - 1) begin
                    m_cnt[i] = 0;
                    m_pos[i] = dr[i] ? (m_pos[i] + 1) % lens[i]
                                     : (m_pos[i] + lens[i] - 1) % lens[i];
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            exp_q.push_back(model_out(i));
            @(posedge clk);
            #1;
            obs_q.push_back(get_obs(i));
        end
    endtask

    task automatic hold_reset(input int i);
        rst[i]   = 1'b1;
        m_pos[i] = 0;
        m_cnt[i] = 0;
        tick(i, 2);
        rst[i] = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] e, o;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b1;   // edges during reset must be ignored
            dr[i] = 1'b1;
            hold_reset(i);
            en[i] = 1'b0;
            checks++;
            if (get_obs(i) !== 16'h0123) begin
                errors++;
                $display("FAIL reset inst%0d: got %h want 0123", i, get_obs(i));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_edge: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_left;
        logic [15:0] e, o;
        en[0] = 1'b1;
        dr[0] = 1'b1;
        tick(0, 1);
        checks++;
        if (out0 !== 16'h1234) begin
            errors++;
            $display("FAIL left_1: got %h want 1234", out0);
        end
        tick(0, 6);
        checks++;
        if (out0 !== 16'h7890) begin
            errors++;
            $display("FAIL left_7: got %h want 7890", out0);
        end
        tick(0, 3);
        checks++;
        if (out0 !== 16'h0123) begin
            errors++;
            $display("FAIL left_wrap: got %h want 0123", out0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL left_edge: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [15:0] e, o;
        tick(0, 3);
        #3;                 // mid-cycle, well away from any edge
        rst[0] = 1'b1;
        #1;
        checks++;
        if (out0 !== 16'h0123) begin
            errors++;
            $display("FAIL async_reset: got %h want 0123", out0);
        end
        #14;                // 1.5 periods of reset in total, spanning one clock edge
        rst[0]   = 1'b0;
        m_pos[0] = 0;
        m_cnt[0] = 0;
        checks++;
        if (out0 !== 16'h0123) begin
            errors++;
            $display("FAIL reset_edge_ignored: got %h want 0123", out0);
        end
        dr[0] = 1'b0;
        tick(0, 1);
        checks++;
        if (out0 !== 16'h9012) begin
            errors++;
            $display("FAIL right_1: got %h want 9012", out0);
        end
        tick(0, 1);
        checks++;
        if (out0 !== 16'h8901) begin
            errors++;
            $display("FAIL right_2: got %h want 8901", out0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL async_edge: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_hold;
        logic [15:0] e, o, held;
        held  = out0;
        en[0] = 1'b0;
        dr[0] = 1'b1;
        tick(0, 5);
        checks++;
        if (out0 !== held) begin
            errors++;
            $display("FAIL hold: got %h want %h", out0, held);
        end
        en[0] = 1'b1;
        tick(0, 3);
        dr[0] = 1'b0;
        tick(0, 2);
        en[0] = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL hold_edge: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_div4;
        logic [15:0] e, o;
        hold_reset(1);
        en[1] = 1'b1;
        dr[1] = 1'b1;
        tick(1, 3);
        checks++;
        if (out1 !== 16'h0123) begin
            errors++;
            $display("FAIL div4_3: got %h want 0123", out1);
        end
        tick(1, 1);
        checks++;
        if (out1 !== 16'h1234) begin
            errors++;
            $display("FAIL div4_4: got %h want 1234", out1);
        end
        tick(1, 4);
        checks++;
        if (out1 !== 16'h2345) begin
            errors++;
            $display("FAIL div4_8: got %h want 2345", out1);
        end
        // dir toggled between steps must not disturb the prescaler
        tick(1, 1);
        dr[1] = 1'b0;
        tick(1, 1);
        dr[1] = 1'b1;
        tick(1, 1);
        dr[1] = 1'b0;
        tick(1, 1);
        checks++;
        if (out1 !== 16'h1234) begin
            errors++;
            $display("FAIL div4_dir: got %h want 1234", out1);
        end
        en[1] = 1'b0;
        tick(1, 3);
        en[1] = 1'b1;
        tick(1, 6);
        en[1] = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL div4_edge: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_msg16;
        logic [15:0] e, o;
        hold_reset(2);
        en[2] = 1'b1;
        dr[2] = 1'b1;
        tick(2, 13);
        checks++;
        if (out2 !== 16'hdef0) begin
            errors++;
            $display("FAIL m16_left13: got %h want def0", out2);
        end
        en[2] = 1'b0;
        hold_reset(2);
        en[2] = 1'b1;
        dr[2] = 1'b0;
        tick(2, 1);
        checks++;
        if (out2 !== 16'hf012) begin
            errors++;
            $display("FAIL m16_right1: got %h want f012", out2);
        end
        tick(2, 3);
        en[2] = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL m16_edge: got %h want %h", o, e);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i]   = 1'b1;
            en[i]    = 1'b0;
            dr[i]    = 1'b1;
            m_pos[i] = 0;
            m_cnt[i] = 0;
        end
        #2;
        test_reset();
        test_left();
        test_async_reset();
        test_hold();
        test_div4();
        test_msg16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/banner.md
BANNER -- requirements
Module: banner

Interface
REQ-001 Parameter DIV, default 1: number of enabled clock cycles per scroll step; legal range 1..2^16.
REQ-002 Parameter MSG_LEN, default 10: message length; legal range 4..16; message digit i has value i (i = 0..MSG_LEN-1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 = prescaler counts and banner scrolls; 0 = all state held.
REQ-006 dir  input  1  scroll direction: 1 = left, 0 = right.
REQ-007 dig_3  output  4  leftmost displayed digit, hex value.
REQ-008 dig_2  output  4  second displayed digit from left.
REQ-009 dig_1  output  4  third displayed digit from left.
REQ-010 dig_0  output  4  rightmost displayed digit.

Function
REQ-011 State SHALL be a position pointer P (range 0..MSG_LEN-1) and a prescaler counter C (range 0..DIV-1).
REQ-012 Outputs SHALL be a function of P only: dig_3 = P, dig_2 = (P+1) mod MSG_LEN, dig_1 = (P+2) mod MSG_LEN, dig_0 = (P+3) mod MSG_LEN.
REQ-013 No combinational path SHALL exist from enable or dir to any output.
REQ-014 With enable=1 on a rising edge: if C = DIV-1, then C <= 0 and a step occurs; otherwise C <= C+1 and there is no step.
REQ-015 With DIV = 1, a step SHALL occur on every enabled rising edge.
REQ-016 On a step with dir=1 (left), P SHALL become (P+1) mod MSG_LEN, so the text moves one digit left and the next message digit enters at dig_0.
REQ-017 On a step with dir=0 (right), P SHALL become (P-1) mod MSG_LEN, so P = 0 wraps to MSG_LEN-1.
REQ-018 Direction SHALL be sampled on the stepping edge only; changing dir between steps SHALL NOT alter C.
REQ-019 With enable=0, P and C SHALL hold and the outputs SHALL stay static.
REQ-020 Output changes SHALL appear one clock edge after the stepping edge is sampled, with no additional latency.
REQ-021 Arithmetic on P SHALL wrap modulo MSG_LEN, never modulo 16, unless MSG_LEN = 16.

Reset
REQ-022 reset=1 SHALL immediately, without waiting for clk, force P = 0 and C = 0, giving dig_3..dig_0 = 0,1,2,3.
REQ-023 While reset=1, clock edges SHALL be ignored.
REQ-024 After reset deasserts, the first step SHALL occur on the DIV-th enabled rising edge.
REQ-025 Reset asserted mid-scroll, including for a non-integer number of clock periods, SHALL discard the current position and prescaler count.

Verification
REQ-026 Reset for 2 cycles, DIV=1, MSG_LEN=10 -> dig_3..dig_0 = 0,1,2,3 during reset.
REQ-027 Then enable=1, dir=1, 1 edge -> 1,2,3,4; after 7 edges -> 7,8,9,0; after 10 edges -> 0,1,2,3 (wrap).
REQ-028 Assert reset for 1.5 periods mid-scroll -> outputs return to 0,1,2,3 asynchronously; then dir=0, 1 edge -> 9,0,1,2; 2 edges -> 8,9,0,1.
REQ-029 enable=0 for 5 edges in any state -> outputs unchanged; re-enable -> scrolling resumes from the held position.
REQ-030 DIV=4, dir=1, from reset -> outputs change only on edges 4, 8, 12, ...; after 8 edges -> 2,3,4,5.
REQ-031 MSG_LEN=16, dir=1, 13 edges from reset -> D,E,F,0; dir=0 from reset, 1 edge -> F,0,1,2.
